instr_mem_loader: RTL and testbench

//  Encoder/writer side of the control decoder: accepts instruction descriptions (kind + register

---
 rtl/instr_enc_pkg.sv | 39 +++
 rtl/instr_word_pack.sv | 37 +++
 rtl/instr_mem_loader.sv | 138 +++++++++++++
 tb/tb_instr_mem_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Package instr_enc_pkg
//  Shared encoding constants for the instruction-memory loader:
//  instruction kind codes, MIPS opcodes and funct fields, the loader
//  state enum, and a helper that assembles an R-type word.
package instr_enc_pkg;

  // Instruction kind codes on the loader's in_kind input (5..7 illegal)
  localparam logic [2:0] KIND_ADD = 3'd0;
  localparam logic [2:0] KIND_SUB = 3'd1;
  localparam logic [2:0] KIND_SLT = 3'd2;
  localparam logic [2:0] KIND_LW  = 3'd3;
  localparam logic [2:0] KIND_SW  = 3'd4;

  // Primary opcodes
  localparam logic [5:0] OP_R  = 6'h00;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  // R-type funct fields
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Loader states. S_PAD is only reachable when NOP padding is built in.
  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_PAD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // R-type layout: opcode | rs | rt | rd | shamt(0) | funct
  function automatic logic [31:0] r_word(input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd,
                                         input logic [5:0] fn);
    return {OP_R, rs, rt, rd, 5'b00000, fn};
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Module instr_word_pack
//  Purely combinational encoder: turns an instruction description into a
//  32-bit MIPS word and flags kinds that have no encoding.
// Ports
//  kind_i     3   instruction kind (see instr_enc_pkg KIND_*)
//  rs_i       5   source register rs
//  rt_i       5   rt field (R-type source, LW destination, SW data)
//  rd_i       5   rd field, used only by R-type
//  imm_i      16  offset, used only by LW/SW
//  word_o     32  encoded word (0 when illegal)
//  illegal_o  1   kind has no encoding
module instr_word_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = 32'h0000_0000;
    illegal_o = 1'b0;
    case (kind_i)
      KIND_ADD: word_o = r_word(rs_i, rt_i, rd_i, FN_ADD);
      KIND_SUB: word_o = r_word(rs_i, rt_i, rd_i, FN_SUB);
      KIND_SLT: word_o = r_word(rs_i, rt_i, rd_i, FN_SLT);
      KIND_LW:  word_o = {OP_LW, rs_i, rt_i, imm_i};
      KIND_SW:  word_o = {OP_SW, rs_i, rt_i, imm_i};
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Module instr_mem_loader
//  Bring-up loader: accepts instruction descriptions over valid/ready,
//  encodes them and writes them to instruction memory at sequential word
//  addresses starting from 0. Each accepted legal instruction produces one
//  registered write in the following cycle.
//  Optional feature macro: INSTR_LOADER_NOP_PAD_EN. When defined, finish
//  moves to S_PAD which fills the remaining words with NOPs (32'h0) before
//  S_DONE. When undefined, finish goes straight to S_DONE.
// Ports
//  clk, rst            clock and synchronous active-high reset
//  start               pulse: restart loading from address 0, clear count/err
//  in_valid/in_ready   instruction handshake
//  in_kind/rs/rt/rd/imm instruction description
//  finish              pulse: no more instructions
//  im_we/im_addr/im_wdata  instruction-memory write port (registered)
//  count               words written since start/rst (reaches DEPTH)
//  err                 sticky illegal-kind flag
//  done                high in S_DONE
module instr_mem_loader
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              finish,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;

  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              xfer;

  instr_word_pack u_pack (
    .kind_i    (in_kind),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  always_comb begin
    in_ready = (state_q == S_LOAD) & ~start & ~finish;
    xfer     = in_valid & in_ready;
  end

  // The final write is registered in S_LOAD/S_PAD and completes in the
  // first S_DONE cycle; no new write is ever scheduled from S_DONE.
  // ptr holds at the last address instead of wrapping, so ptr == count
  // until the memory is full, after which count == DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      ptr_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= 32'h0000_0000;
    end else if (start) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      im_we_q <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (xfer) begin
            if (enc_illegal) begin
              err_q <= 1'b1;
            end else begin
              im_we_q    <= 1'b1;
              im_addr_q  <= ptr_q;
              im_wdata_q <= enc_word;
              count_q    <= count_q + (ADDR_W+1)'(1);
              if (ptr_q == LAST_ADDR) state_q <= S_DONE;
              else                    ptr_q   <= ptr_q + ADDR_W'(1);
            end
          end else if (finish) begin
`ifdef INSTR_LOADER_NOP_PAD_EN
            state_q <= S_PAD;
`else
            state_q <= S_DONE;
`endif
          end
        end
`ifdef INSTR_LOADER_NOP_PAD_EN
        S_PAD: begin
          // Fill with sll $0,$0,0 (all-zero word) up to the last address
          im_we_q    <= 1'b1;
          im_addr_q  <= ptr_q;
          im_wdata_q <= 32'h0000_0000;
          count_q    <= count_q + (ADDR_W+1)'(1);
          if (ptr_q == LAST_ADDR) state_q <= S_DONE;
          else                    ptr_q   <= ptr_q + ADDR_W'(1);
        end
`endif
        S_DONE: state_q <= S_DONE;
        default: state_q <= S_DONE;
      endcase
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign count    = count_q;
  assign err      = err_q;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader. Two instances (32-word and 4-word
// memories) share one stimulus stream; each is compared every cycle
// against a reference model that tracks words written, error flag and
// phase, plus literal checks for the directed scenarios.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, finish;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;

  logic        rdy5, we5, err5, done5;
  logic [4:0]  addr5;
  logic [31:0] wd5;
  logic [5:0]  cnt5;

  logic        rdy2, we2, err2, done2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [2:0]  cnt2;

  instr_mem_loader #(.ADDR_W(5)) u5 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy5),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .finish(finish), .im_we(we5), .im_addr(addr5), .im_wdata(wd5),
    .count(cnt5), .err(err5), .done(done5)
  );

  instr_mem_loader #(.ADDR_W(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy2),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .finish(finish), .im_we(we2), .im_addr(addr2), .im_wdata(wd2),
    .count(cnt2), .err(err2), .done(done2)
  );

  int tests = 0;
  int fails = 0;

  // Reference model, one slot per instance. Phase: 0 loading, 1 padding,
  // 2 done. The next write address is always the number of words written.
  int          depth [2] = '{32, 4};
  int          m_phase [2];
  int          m_cnt [2];
  int          m_err [2];
  int          m_we [2];
  int          m_addr [2];
  logic [31:0] m_wd [2];
  bit          model_live = 1'b0;

  function automatic logic [31:0] encode(input int kind, input int rs, input int rt,
                                         input int rd, input int imm);
    logic [31:0] w;
    int fn;
    fn = (kind == 0) ? 32 : (kind == 1) ? 34 : 42;
    if (kind <= 2)
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
    else
      w = (32'((kind == 3) ? 35 : 43) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int d);
    if (rst) begin
      m_phase[d] = 0; m_cnt[d] = 0; m_err[d] = 0;
      m_we[d] = 0; m_addr[d] = 0; m_wd[d] = 32'h0;
    end else if (start) begin
      m_phase[d] = 0; m_cnt[d] = 0; m_err[d] = 0; m_we[d] = 0;
    end else begin
      m_we[d] = 0;
      if (m_phase[d] == 0) begin
        if (in_valid && !finish) begin
          if (int'(in_kind) > 4) m_err[d] = 1;
          else begin
            m_we[d] = 1; m_addr[d] = m_cnt[d];
            m_wd[d] = encode(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
            m_cnt[d]++;
            if (m_cnt[d] == depth[d]) m_phase[d] = 2;
          end
        end else if (finish) begin
`ifdef INSTR_LOADER_NOP_PAD_EN
          m_phase[d] = 1;
`else
          m_phase[d] = 2;
`endif
        end
      end else if (m_phase[d] == 1) begin
        m_we[d] = 1; m_addr[d] = m_cnt[d]; m_wd[d] = 32'h0;
        m_cnt[d]++;
        if (m_cnt[d] == depth[d]) m_phase[d] = 2;
      end
    end
  endtask

  // One clock cycle with the inputs currently driven.
  task automatic step();
    #1;
    if (model_live) begin
      check("ready5", {31'b0, rdy5}, {31'b0, (m_phase[0] == 0) && !start && !finish});
      check("ready2", {31'b0, rdy2}, {31'b0, (m_phase[1] == 0) && !start && !finish});
    end
    @(posedge clk);
    model_update(0);
    model_update(1);
    model_live = 1'b1;
    #1;
    check("we5",    {31'b0, we5},   m_we[0] != 0);
    check("addr5",  {27'b0, addr5}, 32'(m_addr[0]));
    check("wdata5", wd5,            m_wd[0]);
    check("count5", {26'b0, cnt5},  32'(m_cnt[0]));
    check("err5",   {31'b0, err5},  m_err[0] != 0);
    check("done5",  {31'b0, done5}, m_phase[0] == 2);
    check("we2",    {31'b0, we2},   m_we[1] != 0);
    check("addr2",  {30'b0, addr2}, 32'(m_addr[1]));
    check("wdata2", wd2,            m_wd[1]);
    check("count2", {29'b0, cnt2},  32'(m_cnt[1]));
    check("err2",   {31'b0, err2},  m_err[1] != 0);
    check("done2",  {31'b0, done2}, m_phase[1] == 2);
    if (we5) $display("[TB] t=%0t u5 write addr=%0d data=%h count=%0d", $time, addr5, wd5, cnt5);
    if (we2) $display("[TB] t=%0t u2 write addr=%0d data=%h count=%0d", $time, addr2, wd2, cnt2);
  endtask

  task automatic idle();
    start = 0; finish = 0; in_valid = 0; rst = 0;
  endtask

  task automatic send(input int kind, input int rs, input int rt, input int rd, input int imm);
    in_valid = 1; in_kind = 3'(kind); in_rs = 5'(rs); in_rt = 5'(rt);
    in_rd = 5'(rd); in_imm = 16'(imm);
    step();
    in_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; finish = 0;
    in_kind = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0;
    step(); step();
    rst = 0;
    check("reset_count", {26'b0, cnt5}, 32'd0);
    check("reset_we",    {31'b0, we5},  32'd0);
    check("reset_done",  {31'b0, done5}, 32'd0);
    step();

    // ADD rs1 rt2 rd3 written next cycle at address 0
    send(0, 1, 2, 3, 0);
    check("add_word", wd5, 32'h00221820);
    check("add_we",   {31'b0, we5}, 32'd1);
    check("add_addr", {27'b0, addr5}, 32'd0);
    check("add_count", {26'b0, cnt5}, 32'd1);
    step();

    // Back-to-back SUB, SLT, LW, SW
    pulse_start();
    send(1, 1, 2, 3, 0);  check("sub_word", wd5, 32'h00221822); check("sub_addr", {27'b0, addr5}, 32'd0);
    send(2, 1, 2, 3, 0);  check("slt_word", wd5, 32'h0022182A); check("slt_addr", {27'b0, addr5}, 32'd1);
    send(3, 4, 5, 0, 8);  check("lw_word",  wd5, 32'h8C850008); check("lw_addr",  {27'b0, addr5}, 32'd2);
    send(4, 4, 5, 0, 4);  check("sw_word",  wd5, 32'hAC850004); check("sw_addr",  {27'b0, addr5}, 32'd3);
    step();

    // Illegal kind between two ADDs
    pulse_start();
    send(0, 1, 2, 3, 0);
    send(6, 1, 2, 3, 0);
    check("illegal_no_write", {31'b0, we5}, 32'd0);
    check("illegal_err", {31'b0, err5}, 32'd1);
    send(0, 1, 2, 3, 0);
    check("illegal_next_addr", {27'b0, addr5}, 32'd1);
    step();

    // 4-word instance fills up; a 5th instruction is ignored there
    pulse_start();
    for (int i = 0; i < 4; i++) send(0, i, 2, 3, 0);
    check("full_done2", {31'b0, done2}, 32'd1);
    check("full_count2", {29'b0, cnt2}, 32'd4);
    check("full_addr2", {30'b0, addr2}, 32'd3);
    send(0, 7, 7, 7, 0);
    check("full_no_write2", {31'b0, we2}, 32'd0);
    check("full_ready2", {31'b0, rdy2}, 32'd0);
    step();

    // Two ADDs then finish
    pulse_start();
    send(0, 1, 2, 3, 0);
    send(0, 1, 2, 3, 0);
    finish = 1; step(); finish = 0;
`ifdef INSTR_LOADER_NOP_PAD_EN
    check("finish_pad_state", {31'b0, done5}, 32'd0);
    for (int i = 0; i < 31; i++) step();
    check("pad_count", {26'b0, cnt5}, 32'd32);
`else
    check("finish_done", {31'b0, done5}, 32'd1);
    check("finish_count", {26'b0, cnt5}, 32'd2);
    step();
`endif
    check("finish_done_final", {31'b0, done5}, 32'd1);

    // start together with in_valid mid-load
    pulse_start();
    send(0, 1, 2, 3, 0);
    send(7, 0, 0, 0, 0);
    send(0, 1, 2, 3, 0);
    start = 1; send(1, 9, 9, 9, 0); start = 0;
    check("start_no_write", {31'b0, we5}, 32'd0);
    check("start_count", {26'b0, cnt5}, 32'd0);
    check("start_err", {31'b0, err5}, 32'd0);
    send(0, 1, 2, 3, 0);
    check("start_restart_addr", {27'b0, addr5}, 32'd0);

    // rst mid-operation with a transfer in the same cycle
    send(0, 1, 2, 3, 0);
    rst = 1; send(0, 1, 2, 3, 0); rst = 0;
    check("rst_we", {31'b0, we5}, 32'd0);
    check("rst_wdata", wd5, 32'd0);
    step();

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 39) == 0);
      finish   = ($urandom_range(0, 29) == 0);
      in_valid = ($urandom_range(0, 1) == 1);
      in_kind  = 3'($urandom_range(0, 9) > 7 ? 0 : $urandom_range(0, 7));
      in_rs    = 5'($urandom);
      in_rt    = 5'($urandom);
      in_rd    = 5'($urandom);
      in_imm   = 16'($urandom);
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
